control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Microcoded sequencer for an 8-bit bus-based CPU. Each instruction runs
//   a two-step fetch (T0, T1) followed by one to three execute steps (T2..T4).
//   After HLT it parks in HALT until reset.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   reset       asynchronous, active-high reset; also forces every output to 0
//   opcode      IR[7:4]; valid from T2 onward
//   zero_flag   registered ALU zero flag; used only by JZ at T2
//   carry_flag  registered ALU carry flag; used only by JC at T2
//   pc_out .. out_load   datapath control strobes
//   halt        1 only in HALT
//   step        current microstep (0..4), for debug
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int OPCODE_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero_flag,
   input  logic                carry_flag,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                pc_load,
   output logic                mar_load,
   output logic                ram_out,
   output logic                ram_write,
   output logic                ir_load,
   output logic                ir_out,
   output logic                a_load,
   output logic                a_out,
   output logic                b_load,
   output logic                alu_out,
   output logic                alu_sub,
   output logic                flags_load,
   output logic                out_load,
   output logic                halt,
   output logic [2:0]          step
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(4'h0);
   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
   localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(4'h2);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h3);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h4);
   localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h5);
   localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h6);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h7);
   localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
   localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h9);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

   state_t     state_r;
   logic [2:0] step_r;
   logic [2:0] last_step_s;

   // Final execute step of the current instruction; unlisted opcodes act as NOP.
   always_comb begin
      last_step_s = 3'd2;
      case (opcode)
         OP_LDA, OP_LDB, OP_STA: last_step_s = 3'd3;
         OP_ADD, OP_SUB:         last_step_s = 3'd4;
         default:                last_step_s = 3'd2;
      endcase
   end

   // Sequencer: fetch T0->T1->T2, execute until the last step, then back to T0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_FETCH;
         step_r  <= 3'd0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (step_r == 3'd1) begin
                  state_r <= ST_EXEC;
                  step_r  <= 3'd2;
               end else begin
                  state_r <= ST_FETCH;
                  step_r  <= 3'd1;
               end
            end
            ST_EXEC: begin
               if ((step_r == 3'd2) && (opcode == OP_HLT)) begin
                  state_r <= ST_HALT;
                  step_r  <= 3'd0;
               end else if (step_r >= last_step_s) begin
                  state_r <= ST_FETCH;
                  step_r  <= 3'd0;
               end else begin
                  state_r <= ST_EXEC;
                  step_r  <= step_r + 3'd1;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
               step_r  <= 3'd0;
            end
            default: begin
               state_r <= ST_FETCH;
               step_r  <= 3'd0;
            end
         endcase
      end
   end

   assign step = step_r;

   // Control decode. Gated by reset so an aborted instruction cannot issue a
   // write in the cycle reset arrives. Flags only reach outputs via JZ/JC at T2.
   always_comb begin
      pc_out     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mar_load   = 1'b0;
      ram_out    = 1'b0;
      ram_write  = 1'b0;
      ir_load    = 1'b0;
      ir_out     = 1'b0;
      a_load     = 1'b0;
      a_out      = 1'b0;
      b_load     = 1'b0;
      alu_out    = 1'b0;
      alu_sub    = 1'b0;
      flags_load = 1'b0;
      out_load   = 1'b0;
      halt       = 1'b0;
      if (reset) begin
         halt = 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               case (step_r)
                  3'd0: begin
                     pc_out   = 1'b1;
                     mar_load = 1'b1;
                  end
                  3'd1: begin
                     ram_out = 1'b1;
                     ir_load = 1'b1;
                     pc_inc  = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_EXEC: begin
               case (step_r)
                  3'd2: begin
                     case (opcode)
                        OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
                           ir_out   = 1'b1;
                           mar_load = 1'b1;
                        end
                        OP_LDI: begin
                           ir_out = 1'b1;
                           a_load = 1'b1;
                        end
                        OP_JMP: begin
                           ir_out  = 1'b1;
                           pc_load = 1'b1;
                        end
                        OP_JZ: begin
                           ir_out  = zero_flag;
                           pc_load = zero_flag;
                        end
                        OP_JC: begin
                           ir_out  = carry_flag;
                           pc_load = carry_flag;
                        end
                        OP_OUT: begin
                           a_out    = 1'b1;
                           out_load = 1'b1;
                        end
                        OP_NOP, OP_HLT: ;
                        default: ;
                     endcase
                  end
                  3'd3: begin
                     case (opcode)
                        OP_LDA: begin
                           ram_out = 1'b1;
                           a_load  = 1'b1;
                        end
                        OP_LDB, OP_ADD, OP_SUB: begin
                           ram_out = 1'b1;
                           b_load  = 1'b1;
                        end
                        OP_STA: begin
                           a_out     = 1'b1;
                           ram_write = 1'b1;
                        end
                        default: ;
                     endcase
                  end
                  3'd4: begin
                     case (opcode)
                        OP_ADD: begin
                           alu_out    = 1'b1;
                           a_load     = 1'b1;
                           flags_load = 1'b1;
                        end
                        OP_SUB: begin
                           alu_out    = 1'b1;
                           alu_sub    = 1'b1;
                           a_load     = 1'b1;
                           flags_load = 1'b1;
                        end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
            ST_HALT: halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode;
   logic       zero_flag, carry_flag;
   logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load, ir_out;
   logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;
   logic [2:0] step;

   control_unit #(.OPCODE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag), .carry_flag(carry_flag),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
      .ram_out(ram_out), .ram_write(ram_write), .ir_load(ir_load), .ir_out(ir_out),
      .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
      .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load), .halt(halt),
      .step(step)
   );

   always #5 clk = ~clk;

   localparam logic [15:0] W_PC_OUT = 16'h8000, W_PC_INC = 16'h4000, W_PC_LOAD = 16'h2000,
      W_MAR_LOAD = 16'h1000, W_RAM_OUT = 16'h0800, W_RAM_WRITE = 16'h0400,
      W_IR_LOAD = 16'h0200, W_IR_OUT = 16'h0100, W_A_LOAD = 16'h0080, W_A_OUT = 16'h0040,
      W_B_LOAD = 16'h0020, W_ALU_OUT = 16'h0010, W_ALU_SUB = 16'h0008,
      W_FLAGS_LOAD = 16'h0004, W_OUT_LOAD = 16'h0002, W_HALT = 16'h0001;

   logic [15:0] ctrl;
   assign ctrl = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load, ir_out,
                  a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt};

   // ---------------- datapath model (environment for the sequencer) ----------
   logic [7:0] prog [16];
   logic [7:0] ram  [16];
   logic [3:0] pc, mar;
   logic [7:0] ir, a, b, out_val;
   logic       zf, cf;
   logic [7:0] bus;
   logic [8:0] alu_full;
   int         flags_cnt, sub_cnt, wr_cnt;
   logic [3:0] wr_mar;

   assign opcode     = ir[7:4];
   assign zero_flag  = zf;
   assign carry_flag = cf;
   assign alu_full   = alu_sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});

   always_comb begin
      bus = 8'h00;
      if (pc_out)       bus = {4'h0, pc};
      else if (ram_out) bus = ram[mar];
      else if (ir_out)  bus = {4'h0, ir[3:0]};
      else if (a_out)   bus = a;
      else if (alu_out) bus = alu_full[7:0];
      else              bus = 8'h00;
   end

   // Registers of the datapath; A and B deliberately survive reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) ram[i] <= prog[i];
         pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; zf <= 1'b0; cf <= 1'b0; out_val <= 8'h00;
         flags_cnt <= 0; sub_cnt <= 0; wr_cnt <= 0; wr_mar <= 4'h0;
      end else begin
         if (mar_load)  mar <= bus[3:0];
         if (ram_write) ram[mar] <= bus;
         if (ir_load)   ir <= bus;
         if (a_load)    a <= bus;
         if (b_load)    b <= bus;
         if (out_load)  out_val <= bus;
         if (flags_load) begin
            zf <= (alu_full[7:0] == 8'h00);
            cf <= alu_full[8];
         end
         if (pc_load)     pc <= bus[3:0];
         else if (pc_inc) pc <= pc + 4'h1;
         if (flags_load) flags_cnt <= flags_cnt + 1;
         if (alu_sub)    sub_cnt <= sub_cnt + 1;
         if (ram_write) begin
            wr_cnt <= wr_cnt + 1;
            wr_mar <= mar;
         end
      end
   end

   // ---------------- scoreboard ------------------------------------------------
   logic [18:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   task automatic push_w(input logic [2:0] st, input logic [15:0] w);
      exp_q.push_back({st, w});
   endtask

   // Expected control words of one instruction, written from the microcode table.
   task automatic exp_instr(input logic [3:0] op, input logic taken);
      push_w(3'd0, W_PC_OUT | W_MAR_LOAD);
      push_w(3'd1, W_RAM_OUT | W_IR_LOAD | W_PC_INC);
      case (op)
         4'h1: begin push_w(3'd2, W_IR_OUT | W_MAR_LOAD); push_w(3'd3, W_RAM_OUT | W_A_LOAD); end
         4'h2: begin push_w(3'd2, W_IR_OUT | W_MAR_LOAD); push_w(3'd3, W_RAM_OUT | W_B_LOAD); end
         4'h3: begin
            push_w(3'd2, W_IR_OUT | W_MAR_LOAD); push_w(3'd3, W_RAM_OUT | W_B_LOAD);
            push_w(3'd4, W_ALU_OUT | W_A_LOAD | W_FLAGS_LOAD);
         end
         4'h4: begin
            push_w(3'd2, W_IR_OUT | W_MAR_LOAD); push_w(3'd3, W_RAM_OUT | W_B_LOAD);
            push_w(3'd4, W_ALU_OUT | W_ALU_SUB | W_A_LOAD | W_FLAGS_LOAD);
         end
         4'h5: begin push_w(3'd2, W_IR_OUT | W_MAR_LOAD); push_w(3'd3, W_A_OUT | W_RAM_WRITE); end
         4'h6: push_w(3'd2, W_IR_OUT | W_A_LOAD);
         4'h7: push_w(3'd2, W_IR_OUT | W_PC_LOAD);
         4'h8, 4'h9: push_w(3'd2, taken ? (W_IR_OUT | W_PC_LOAD) : 16'h0000);
         4'hE: push_w(3'd2, W_A_OUT | W_OUT_LOAD);
         default: push_w(3'd2, 16'h0000);
      endcase
   endtask

   task automatic exp_halt(input int n);
      for (int i = 0; i < n; i++) push_w(3'd0, W_HALT);
   endtask

   // Pops one expectation per cycle and compares it with the DUT outputs;
   // also checks bus exclusivity and read/write exclusivity every cycle.
   task automatic drain(input int bound);
      int n;
      logic [18:0] e;
      n = 0;
      while (exp_q.size() > 0 && n < bound) begin
         @(negedge clk);
         n++;
         total++;
         if (($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) || (ram_write && ram_out)) begin
            bad++;
            $display("FAIL bus_excl t=%0t drivers=%b rw=%b ro=%b", $time,
                     {pc_out, ram_out, ir_out, a_out, alu_out}, ram_write, ram_out);
         end
         e = exp_q.pop_front();
         total++;
         if ((ctrl !== e[15:0]) || (!e[0] && (step !== e[18:16]))) begin
            bad++;
            $display("FAIL ctrl_word t=%0t got ctrl=%h step=%0d want ctrl=%h step=%0d",
                     $time, ctrl, step, e[15:0], e[18:16]);
         end
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   task automatic start_prog();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // ---------------- scenarios -------------------------------------------------
   task automatic test_reset();
      clear_prog();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (ctrl !== 16'h0000) begin bad++; $display("FAIL reset_ctrl got=%h want=0000", ctrl); end
      total++;
      if (step !== 3'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", step); end
   endtask

   task automatic test_lda_hlt();
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'hF0; prog[14] = 8'hAB;
      exp_instr(4'h1, 1'b0); exp_instr(4'hF, 1'b0); exp_halt(21);
      start_prog();
      drain(60);
      total++;
      if (a !== 8'hAB) begin bad++; $display("FAIL lda_a got=%h want=ab", a); end
   endtask

   task automatic test_add_out();
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h3F; prog[2] = 8'hE0; prog[3] = 8'hF0;
      prog[14] = 8'h05; prog[15] = 8'h03;
      exp_instr(4'h1, 1'b0); exp_instr(4'h3, 1'b0); exp_instr(4'hE, 1'b0);
      exp_instr(4'hF, 1'b0); exp_halt(2);
      start_prog();
      drain(60);
      total++;
      if (out_val !== 8'h08) begin bad++; $display("FAIL add_out got=%h want=08", out_val); end
      total++;
      if (flags_cnt != 1) begin bad++; $display("FAIL add_flags_pulses got=%0d want=1", flags_cnt); end
      total++;
      if (sub_cnt != 0) begin bad++; $display("FAIL add_alu_sub got=%0d want=0", sub_cnt); end
   endtask

   task automatic test_sub_jz(input logic [7:0] operand, input logic taken);
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h4F; prog[2] = 8'h86; prog[3] = 8'hE0;
      prog[4] = 8'hF0; prog[6] = 8'hF0; prog[14] = 8'h05; prog[15] = operand;
      exp_instr(4'h1, 1'b0); exp_instr(4'h4, 1'b0); exp_instr(4'h8, taken);
      if (taken) begin
         exp_instr(4'hF, 1'b0);
      end else begin
         exp_instr(4'hE, 1'b0); exp_instr(4'hF, 1'b0);
      end
      exp_halt(2);
      start_prog();
      drain(60);
      total++;
      if (zf !== taken) begin bad++; $display("FAIL sub_zero got=%b want=%b", zf, taken); end
      total++;
      if (pc !== (taken ? 4'h7 : 4'h5)) begin
         bad++; $display("FAIL jz_pc got=%h want=%h", pc, taken ? 4'h7 : 4'h5);
      end
      total++;
      if (out_val !== (taken ? 8'h00 : 8'h01)) begin
         bad++; $display("FAIL jz_out got=%h want=%h", out_val, taken ? 8'h00 : 8'h01);
      end
   endtask

   task automatic test_sta_nop();
      clear_prog();
      prog[0] = 8'hB0; prog[1] = 8'h1E; prog[2] = 8'h5D; prog[3] = 8'h97; prog[4] = 8'hF0;
      prog[14] = 8'h5A;
      exp_instr(4'hB, 1'b0); exp_instr(4'h1, 1'b0); exp_instr(4'h5, 1'b0);
      exp_instr(4'h9, 1'b0); exp_instr(4'hF, 1'b0); exp_halt(2);
      start_prog();
      drain(60);
      total++;
      if (ram[13] !== 8'h5A) begin bad++; $display("FAIL sta_ram got=%h want=5a", ram[13]); end
      total++;
      if (wr_cnt != 1) begin bad++; $display("FAIL sta_wr_cycles got=%0d want=1", wr_cnt); end
      total++;
      if (wr_mar !== 4'hD) begin bad++; $display("FAIL sta_mar got=%h want=d", wr_mar); end
   endtask

   task automatic test_ldi_ldb_jmp();
      clear_prog();
      prog[0] = 8'h63; prog[1] = 8'h2E; prog[2] = 8'h74; prog[3] = 8'hF0;
      prog[4] = 8'hE0; prog[5] = 8'h00; prog[6] = 8'hF0; prog[14] = 8'h77;
      exp_instr(4'h6, 1'b0); exp_instr(4'h2, 1'b0); exp_instr(4'h7, 1'b0);
      exp_instr(4'hE, 1'b0); exp_instr(4'h0, 1'b0); exp_instr(4'hF, 1'b0); exp_halt(2);
      start_prog();
      drain(60);
      total++;
      if (out_val !== 8'h03) begin bad++; $display("FAIL ldi_out got=%h want=03", out_val); end
      total++;
      if (b !== 8'h77) begin bad++; $display("FAIL ldb_b got=%h want=77", b); end
      total++;
      if (pc !== 4'h7) begin bad++; $display("FAIL jmp_pc got=%h want=7", pc); end
   endtask

   task automatic test_reset_mid_add();
      clear_prog();
      prog[0] = 8'h1E; prog[1] = 8'h3F; prog[14] = 8'h05; prog[15] = 8'h03;
      exp_instr(4'h1, 1'b0);
      push_w(3'd0, W_PC_OUT | W_MAR_LOAD);
      push_w(3'd1, W_RAM_OUT | W_IR_LOAD | W_PC_INC);
      push_w(3'd2, W_IR_OUT | W_MAR_LOAD);
      start_prog();
      drain(30);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if (ctrl !== 16'h0000) begin bad++; $display("FAIL mid_reset_ctrl got=%h want=0000", ctrl); end
      total++;
      if (step !== 3'd0) begin bad++; $display("FAIL mid_reset_step got=%0d want=0", step); end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (a !== 8'h05) begin bad++; $display("FAIL mid_reset_a got=%h want=05", a); end
      exp_instr(4'h1, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      drain(30);
      total++;
      if (pc !== 4'h1) begin bad++; $display("FAIL mid_reset_pc got=%h want=1", pc); end
   endtask

   initial begin
      test_reset();
      test_lda_hlt();
      test_add_out();
      test_sub_jz(8'h05, 1'b1);
      test_sub_jz(8'h04, 1'b0);
      test_sta_nop();
      test_ldi_ldb_jmp();
      test_reset_mid_add();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
